// File: rtl/trng_sampler_if.sv
// Output word port of the TRNG conditioner: data word plus valid/ready handshake.
interface trng_sampler_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/trng_sampler.sv
// Ring-oscillator entropy conditioner: synchronise, XOR-fold, optional von Neumann
// debias, LSB-first packing into words, repetition-count health test and drop counter.
module trng_sampler #(
    parameter int N_OSC     = 4,
    parameter int WIDTH     = 8,
    parameter int DIV       = 16,
    parameter int REP_LIMIT = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             debias_en,
    input  logic [N_OSC-1:0] osc_in,
    trng_sampler_if.master   out_port,
    output logic             health_fail,
    input  logic             health_clr,
    output logic [7:0]       drop_cnt
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int RW = $clog2(REP_LIMIT + 1);
    localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [RW-1:0] REP_MAX = RW'(REP_LIMIT);
    localparam logic [SW-1:0] LAST    = SW'(WIDTH - 1);

    logic [N_OSC-1:0] sync1, sync2;
    logic [CW-1:0]    div_cnt;
    logic             strobe, raw;
    logic             last_raw;
    logic [RW-1:0]    rep, rep_next;
    logic             have_a, a_bit, debias_q;
    logic [WIDTH-1:0] shift, word;
    logic [SW-1:0]    sh_cnt;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             emit, emit_bit, accept, word_done, load;

    assign out_port.out_data  = data_q;
    assign out_port.out_valid = valid_q && !health_fail;

    // Strobe, raw bit, bit emission and word-completion decisions.
    always_comb begin
        strobe    = en && (div_cnt == CNT_MAX);
        raw       = ^sync2;
        accept    = valid_q && !health_fail && out_port.out_ready;
        emit      = 1'b0;
        emit_bit  = raw;
        if (!health_fail && (debias_en == debias_q) && strobe) begin
            if (!debias_en) begin
                emit = 1'b1;
            end else if (have_a && (a_bit != raw)) begin
                emit     = 1'b1;
                emit_bit = a_bit;
            end
        end
        word          = shift;
        word[sh_cnt]  = emit_bit;
        word_done     = emit && (sh_cnt == LAST);
        load          = word_done && (!valid_q || accept);
        if (raw == last_raw) begin
            rep_next = (rep == REP_MAX) ? rep : rep + 1'b1;
        end else begin
            rep_next = RW'(1);
        end
    end

    // Two-flop synchroniser on every oscillator input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= osc_in;
            sync2 <= sync1;
        end
    end

    // Sample-rate divider, advancing only while enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (en) begin
            div_cnt <= (div_cnt == CNT_MAX) ? '0 : div_cnt + 1'b1;
        end
    end

    // Repetition-count health test; a clear takes priority over a trip.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep         <= '0;
            health_fail <= 1'b0;
            last_raw    <= 1'b0;
        end else begin
            if (health_clr) begin
                rep         <= '0;
                health_fail <= 1'b0;
            end else if (strobe) begin
                rep <= rep_next;
                if (rep_next == REP_MAX) begin
                    health_fail <= 1'b1;
                end
            end
            if (strobe) begin
                last_raw <= raw;
            end
        end
    end

    // Von Neumann pair state, dropped on health failure or a debias mode change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            debias_q <= 1'b0;
            have_a   <= 1'b0;
            a_bit    <= 1'b0;
        end else begin
            debias_q <= debias_en;
            if (health_fail || (debias_en != debias_q)) begin
                have_a <= 1'b0;
            end else if (strobe && debias_en) begin
                if (!have_a) begin
                    have_a <= 1'b1;
                    a_bit  <= raw;
                end else begin
                    have_a <= 1'b0;
                end
            end
        end
    end

    // LSB-first bit packing; the partial word is discarded while the health test fails.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift  <= '0;
            sh_cnt <= '0;
        end else if (health_fail) begin
            shift  <= '0;
            sh_cnt <= '0;
        end else if (emit) begin
            if (word_done) begin
                shift  <= '0;
                sh_cnt <= '0;
            end else begin
                shift  <= word;
                sh_cnt <= sh_cnt + 1'b1;
            end
        end
    end

    // Output register and valid flag; a load in the accepting cycle keeps valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            data_q  <= word;
            valid_q <= 1'b1;
        end else if (accept) begin
            valid_q <= 1'b0;
        end
    end

    // Saturating count of completed words lost to a full output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (word_done && !load && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_trng_sampler.sv
// Self-checking bench for trng_sampler: directed scenarios plus randomized traffic,
// all compared every cycle against a queue-based behavioural model.
module tb_trng_sampler;
    localparam int N_OSC     = 4;
    localparam int WIDTH     = 8;
    localparam int DIV       = 4;
    localparam int REP_LIMIT = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             debias_en = 1'b0;
    logic             health_clr = 1'b0;
    logic [N_OSC-1:0] osc_in = '0;
    logic             health_fail;
    logic [7:0]       drop_cnt;

    trng_sampler_if #(.WIDTH(WIDTH)) bus ();

    trng_sampler #(.N_OSC(N_OSC), .WIDTH(WIDTH), .DIV(DIV), .REP_LIMIT(REP_LIMIT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .debias_en  (debias_en),
        .osc_in     (osc_in),
        .out_port   (bus.master),
        .health_fail(health_fail),
        .health_clr (health_clr),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    int               m_cnt, m_rep, m_drops;
    bit               m_last, m_fail, m_dprev, m_valid;
    bit [WIDTH-1:0]   m_data;
    logic [N_OSC-1:0] m_s1, m_s2;
    bit               m_q[$];
    bit               m_pair[$];

    always @(posedge clk or negedge rst_n) begin : model
        bit stb, r, acc, loaded;
        bit [WIDTH-1:0] w;
        if (!rst_n) begin
            m_cnt = 0; m_rep = 0; m_drops = 0;
            m_last = 0; m_fail = 0; m_dprev = 0; m_valid = 0;
            m_data = '0; m_s1 = '0; m_s2 = '0;
            m_q.delete(); m_pair.delete();
        end else begin
            stb    = en && (m_cnt == DIV - 1);
            r      = ^m_s2;
            acc    = m_valid && !m_fail && bus.out_ready;
            loaded = 0;
            if (m_fail) begin
                m_q.delete();
                m_pair.delete();
            end else if (debias_en != m_dprev) begin
                m_pair.delete();
            end else if (stb) begin
                if (!debias_en) m_q.push_back(r);
                else begin
                    m_pair.push_back(r);
                    if (m_pair.size() == 2) begin
                        if (m_pair[0] != m_pair[1]) m_q.push_back(m_pair[0]);
                        m_pair.delete();
                    end
                end
                if (m_q.size() == WIDTH) begin
                    for (int i = 0; i < WIDTH; i++) w[i] = m_q[i];
                    m_q.delete();
                    if (!m_valid || acc) begin
                        m_data = w;
                        loaded = 1;
                    end else if (m_drops < 255) m_drops++;
                end
            end
            if (loaded) m_valid = 1;
            else if (acc) m_valid = 0;
            if (health_clr) begin
                m_fail = 0;
                m_rep  = 0;
            end else if (stb) begin
                if (r == m_last) m_rep = (m_rep < REP_LIMIT) ? m_rep + 1 : m_rep;
                else m_rep = 1;
                if (m_rep == REP_LIMIT) m_fail = 1;
            end
            if (stb) m_last = r;
            if (en) m_cnt = (m_cnt + 1) % DIV;
            m_dprev = debias_en;
            m_s2 = m_s1;
            m_s1 = osc_in;
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            check("valid", 32'(bus.out_valid), 32'(m_valid && !m_fail));
            check("data",  32'(bus.out_data),  32'(m_data));
            check("fail",  32'(health_fail),   32'(m_fail));
            check("drop",  32'(drop_cnt),      32'(m_drops));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_raw(input bit r);
        logic [N_OSC-1:0] v;
        v = N_OSC'($urandom);
        if ((^v) != r) v[0] = ~v[0];
        osc_in = v;
        en = 1'b1;
    endtask

    task automatic win(input bit r);
        set_raw(r);
        repeat (DIV) @(negedge clk);
    endtask

    task automatic word_bits(input logic [WIDTH-1:0] w);
        for (int i = 0; i < WIDTH; i++) win(w[i]);
    endtask

    task automatic set_debias(input bit b);
        en = 1'b0;
        debias_en = b;
        @(negedge clk);
    endtask

    logic [19:0]      seq;
    logic [WIDTH-1:0] w, last_w;

    initial begin
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data",  32'(bus.out_data),  32'd0);
        check("rst_fail",  32'(health_fail),   32'd0);
        check("rst_drop",  32'(drop_cnt),      32'd0);
        rst_n = 1'b1;

        // Raw mode, pattern 1,0,1,1,0,0,1,0 packs LSB-first to 0x4D.
        word_bits(8'h4D);
        check("t1_valid", 32'(bus.out_valid), 32'd1);
        check("t1_data",  32'(bus.out_data),  32'h4D);
        check("t1_model", 32'(m_data),        32'h4D);

        // Debias: only 01/10 pairs contribute; emitted 0,1,1,0,1,0,0,1 -> 0x96.
        set_debias(1'b1);
        bus.out_ready = 1'b0;
        seq = 20'b0110_1001_1001_0011_0110;
        for (int i = 0; i < 20; i++) win(seq[19-i]);
        check("t2_valid", 32'(bus.out_valid),     32'd1);
        check("t2_data",  32'(bus.out_data),      32'h96);
        check("t2_first", 32'(bus.out_data[1:0]), 32'd2);
        check("t2_model", 32'(m_data),            32'h96);

        // Health trip with a held word, then clear and restart from an empty word.
        set_debias(1'b0);
        for (int i = 0; i < REP_LIMIT; i++) win(1'b0);
        check("t3_fail",  32'(health_fail),   32'd1);
        check("t3_valid", 32'(bus.out_valid), 32'd0);
        check("t3_held",  32'(bus.out_data),  32'h96);
        en = 1'b0;
        health_clr = 1'b1;
        @(negedge clk);
        health_clr = 1'b0;
        check("t3_clr_fail",  32'(health_fail),   32'd0);
        check("t3_clr_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        word_bits(8'h4D);
        check("t3_restart", 32'(bus.out_data), 32'h4D);
        check("t3_drop",    32'(drop_cnt),     32'd0);

        // Stalled consumer: first word held, later ones dropped, counter saturates.
        en = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b0;
        word_bits(8'hA5);
        word_bits(8'h3C);
        word_bits(8'h69);
        check("t4_data",  32'(bus.out_data), 32'hA5);
        check("t4_drop2", 32'(drop_cnt),     32'd2);
        check("t4_model", 32'(m_drops),      32'd2);
        last_w = 8'h69;
        for (int k = 0; k < 298; k++) begin
            w = WIDTH'($urandom);
            w[3] = ~w[2];
            w[7] = ~w[6];
            w[0] = ~last_w[7];
            word_bits(w);
            last_w = w;
        end
        check("t4_sat",  32'(drop_cnt),     32'd255);
        check("t4_hold", 32'(bus.out_data), 32'hA5);

        // Asynchronous reset mid-word while a word is presented.
        win(1'b1);
        win(1'b0);
        win(1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_valid", 32'(bus.out_valid), 32'd0);
        check("t5_data",  32'(bus.out_data),  32'd0);
        check("t5_fail",  32'(health_fail),   32'd0);
        check("t5_drop",  32'(drop_cnt),      32'd0);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        word_bits(8'h4D);
        check("t5_fresh", 32'(bus.out_data),  32'h4D);

        // New word completes in the very cycle the held one is accepted.
        w = 8'hC3;
        for (int i = 0; i < WIDTH - 1; i++) win(w[i]);
        set_raw(w[WIDTH-1]);
        repeat (DIV - 1) @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("t6_valid", 32'(bus.out_valid), 32'd1);
        check("t6_data",  32'(bus.out_data),  32'hC3);
        check("t6_drop",  32'(drop_cnt),      32'd0);

        // Randomized traffic; debias changes only in cycles with sampling paused.
        for (int c = 0; c < 6000; c++) begin
            if (($urandom % 100) < 3) begin
                en = 1'b0;
                debias_en = ~debias_en;
            end else begin
                en = (($urandom % 8) != 0);
            end
            bus.out_ready = (($urandom % 3) != 0);
            health_clr = (($urandom % 60) == 0);
            if (($urandom % 4) == 0) osc_in = N_OSC'($urandom);
            @(negedge clk);
        end
        health_clr = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
